fifo_wr_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares the single write port of the output FIFO among several byte producers (ReLU result writer, comparator result, PISO debug capture, host test path). A granted producer owns the FIFO until it completes a packet (LAST beat) or hits the packet-length cap. Sits between the datapath producers and the `fifo` instance, under the top-level FSM, which gates it with EN_ARB.

---
 rtl/fifo_wr_arbiter_if.sv | 53 +++++
 rtl/fifo_wr_arbiter.sv | 173 +++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_if
// Bundles the producer request side and the FIFO write side of the
// fifo_wr_arbiter, together with the EN_ARB gate from the top-level FSM.
//
// Signals
//   EN_ARB      arbiter enable (0 = no new grants, no transfers)
//   REQ_VALID   per-requester beat valid
//   REQ_LAST    per-requester last beat of packet (qualified by REQ_VALID)
//   REQ_DATA    packed beats, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   REQ_READY   per-requester beat accept
//   FIFO_FULL   FIFO full flag
//   FIFO_WR_EN  FIFO write strobe
//   FIFO_DATA   FIFO write data
//   GRANT_IDX   current or last owner index
//   ARB_BUSY    a packet is currently owned
//   PKT_DONE    1-cycle pulse, cycle after a packet's final beat
//   PKT_TRUNC   1-cycle pulse, cycle after a forced release at MAX_PKT
//
// Modports
//   master : producers / FIFO / sequencer side (drives requests, sees grants)
//   slave  : arbiter side
// ---------------------------------------------------------------------------
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int IDX_W      = 2
);
  logic                          EN_ARB;
  logic [NUM_REQ-1:0]            REQ_VALID;
  logic [NUM_REQ-1:0]            REQ_LAST;
  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA;
  logic [NUM_REQ-1:0]            REQ_READY;
  logic                          FIFO_FULL;
  logic                          FIFO_WR_EN;
  logic [DATA_WIDTH-1:0]         FIFO_DATA;
  logic [IDX_W-1:0]              GRANT_IDX;
  logic                          ARB_BUSY;
  logic                          PKT_DONE;
  logic                          PKT_TRUNC;

  modport master (
    output EN_ARB, REQ_VALID, REQ_LAST, REQ_DATA, FIFO_FULL,
    input  REQ_READY, FIFO_WR_EN, FIFO_DATA, GRANT_IDX, ARB_BUSY,
           PKT_DONE, PKT_TRUNC
  );

  modport slave (
    input  EN_ARB, REQ_VALID, REQ_LAST, REQ_DATA, FIFO_FULL,
    output REQ_READY, FIFO_WR_EN, FIFO_DATA, GRANT_IDX, ARB_BUSY,
           PKT_DONE, PKT_TRUNC
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
// Packet-level round-robin arbiter sharing the single FIFO write port among
// NUM_REQ byte producers. A granted producer owns the port until it sends a
// LAST beat or reaches MAX_PKT beats, then ownership always passes through
// IDLE (one dead cycle) before the next grant.
//
// Ports
//   CLKEXT   clock, rising edge
//   RST_GLO  asynchronous active-high reset
//   arb      fifo_wr_arbiter_if.slave (request bus, FIFO write bus, status)
//
// Build option
//   FIFO_ARB_PRIO0_EN : when defined, requester 0 wins every IDLE arbitration
//                       it takes part in; it never preempts an owned packet,
//                       and its release leaves the round-robin pointer alone.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no owner; arbitrate among valid requesters when EN_ARB=1
// GRANT | owner streams beats to the FIFO until LAST or MAX_PKT beats
// ---------------------------------------------------------------------------
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_PKT    = 16,
  parameter int IDX_W      = 2
) (
  input logic           CLKEXT,
  input logic           RST_GLO,
  fifo_wr_arbiter_if.slave arb
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]      owner_q, owner_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic                  pkt_done_q, pkt_done_d;
  logic                  pkt_trunc_q, pkt_trunc_d;

  logic                  pick_vld;
  logic [IDX_W-1:0]      pick_idx;
  logic [IDX_W-1:0]      cand_idx;
  logic [IDX_W-1:0]      next_ptr;

  logic                  own_valid;
  logic                  own_last;
  logic [DATA_WIDTH-1:0] own_data;
  logic                  grant_rdy;
  logic                  accept;
  logic                  at_cap;
  logic                  release_beat;
  logic [NUM_REQ-1:0]    ready_vec;

  // Search from rr_ptr upward with wrap modulo NUM_REQ, so indices at or above
  // NUM_REQ are never produced even when NUM_REQ is not a power of two.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_idx = IDX_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!pick_vld && arb.REQ_VALID[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
`ifdef FIFO_ARB_PRIO0_EN
    if (arb.REQ_VALID[0]) begin
      pick_vld = 1'b1;
      pick_idx = '0;
    end
`endif
  end

  // Owner-side beat mux.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    own_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (owner_q == IDX_W'(i)) begin
        own_valid = arb.REQ_VALID[i];
        own_last  = arb.REQ_LAST[i];
        own_data  = arb.REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign grant_rdy    = (state_q == ST_GRANT) && arb.EN_ARB && !arb.FIFO_FULL;
  assign accept       = grant_rdy && own_valid;
  assign at_cap       = (beat_cnt_q == 8'(MAX_PKT - 1));
  assign release_beat = accept && (own_last || at_cap);
  assign next_ptr     = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready_vec[i] = grant_rdy && (owner_q == IDX_W'(i));
    end
  end

  always_ff @(posedge CLKEXT or posedge RST_GLO) begin
    if (RST_GLO) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      beat_cnt_q  <= '0;
      pkt_done_q  <= 1'b0;
      pkt_trunc_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      beat_cnt_q  <= beat_cnt_d;
      pkt_done_q  <= pkt_done_d;
      pkt_trunc_q <= pkt_trunc_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    beat_cnt_d  = beat_cnt_q;
    pkt_done_d  = 1'b0;
    pkt_trunc_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb.EN_ARB && pick_vld) begin
          state_d    = ST_GRANT;
          owner_d    = pick_idx;
          beat_cnt_d = '0;
        end
      end
      ST_GRANT: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
        if (release_beat) begin
          state_d     = ST_IDLE;
          pkt_done_d  = 1'b1;
          // A LAST beat landing exactly on the cap is a normal completion.
          pkt_trunc_d = !own_last;
`ifdef FIFO_ARB_PRIO0_EN
          if (owner_q != '0) begin
            rr_ptr_d = next_ptr;
          end
`else
          rr_ptr_d = next_ptr;
`endif
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign arb.REQ_READY  = ready_vec;
  assign arb.FIFO_WR_EN = accept;
  assign arb.FIFO_DATA  = (state_q == ST_GRANT) ? own_data : '0;
  assign arb.GRANT_IDX  = owner_q;
  assign arb.ARB_BUSY   = (state_q == ST_GRANT);
  assign arb.PKT_DONE   = pkt_done_q;
  assign arb.PKT_TRUNC  = pkt_trunc_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int MP = 16;
  localparam int IW = 2;

  logic CLKEXT = 1'b0;
  logic RST_GLO;

  always #5 CLKEXT = ~CLKEXT;

  fifo_wr_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .IDX_W(IW)) bus ();

  fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_PKT(MP), .IDX_W(IW)) dut (
    .CLKEXT (CLKEXT),
    .RST_GLO(RST_GLO),
    .arb    (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Source beats per requester: {last, data}; expected FIFO bytes in order.
  logic [8:0] src_q [NR][$];
  logic [7:0] exp_q [$];
  int         grant_log [$];
  int         wr_cyc [$];

  int         cyc = 0, wr_cnt = 0, done_cnt = 0, trunc_cnt = 0, bc = 0;
  logic       rel_prev = 1'b0, trunc_prev = 1'b0, busy_prev = 1'b0;
  logic [NR-1:0] acc = '0;
  logic [NR-1:0] hs;
  int         own;
  logic       cur_last;

  task automatic drive_reqs();
    logic [NR-1:0]    v, l;
    logic [NR*DW-1:0] d;
    v = '0; l = '0; d = '0;
    for (int i = 0; i < NR; i++) begin
      if (src_q[i].size() > 0) begin
        v[i] = 1'b1;
        l[i] = src_q[i][0][8];
        d[i*DW +: DW] = src_q[i][0][7:0];
      end
    end
    bus.REQ_VALID = v;
    bus.REQ_LAST  = l;
    bus.REQ_DATA  = d;
  endtask

  task automatic push_beat(input int r, input logic [7:0] d, input logic l);
    src_q[r].push_back({l, d});
    drive_reqs();
  endtask

  // Producer side: retire accepted beats just after the edge that took them.
  always @(posedge CLKEXT) begin
    #1;
    for (int i = 0; i < NR; i++) begin
      if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    end
    drive_reqs();
  end

  // Monitor: sample mid-cycle, check FIFO writes against the scoreboard and the
  // done/trunc pulses against a beat-count model.
  always @(negedge CLKEXT) begin
    cyc++;
    if (RST_GLO) begin
      acc = '0; bc = 0; rel_prev = 1'b0; trunc_prev = 1'b0; busy_prev = 1'b0;
    end else begin
      hs = bus.REQ_VALID & bus.REQ_READY;
      check_val("pkt_done", 32'(bus.PKT_DONE), 32'(rel_prev));
      check_val("pkt_trunc", 32'(bus.PKT_TRUNC), 32'(trunc_prev));
      check_val("wr_en_vs_hs", 32'(bus.FIFO_WR_EN), 32'(|hs));
      check_val("ready_onehot", 32'($countones(bus.REQ_READY) <= 1), 32'd1);
      if (!bus.ARB_BUSY) check_val("idle_data", 32'(bus.FIFO_DATA), 32'd0);
      if (bus.ARB_BUSY && !busy_prev) grant_log.push_back(int'(bus.GRANT_IDX));
      busy_prev = bus.ARB_BUSY;
      if (bus.PKT_DONE) done_cnt++;
      if (bus.PKT_TRUNC) trunc_cnt++;
      rel_prev = 1'b0;
      trunc_prev = 1'b0;
      if (bus.FIFO_WR_EN) begin
        wr_cnt++;
        wr_cyc.push_back(cyc);
        if (exp_q.size() == 0) check_val("fifo_unexpected", 32'(bus.FIFO_DATA), 32'h1ff);
        else check_val("fifo_data", 32'(bus.FIFO_DATA), 32'(exp_q.pop_front()));
        own = 0;
        for (int i = 0; i < NR; i++) if (hs[i]) own = i;
        cur_last = (src_q[own].size() > 0) ? src_q[own][0][8] : 1'b0;
        bc++;
        if (cur_last || bc == MP) begin
          rel_prev = 1'b1;
          trunc_prev = !cur_last;
          bc = 0;
        end
      end
      acc = hs;
    end
  end

  task automatic wait_writes(input int target, input int budget);
    int n;
    n = 0;
    do begin
      @(posedge CLKEXT);
      n++;
    end while (wr_cnt < target && n < budget);
    if (wr_cnt < target) check_val("timeout_writes", 32'(wr_cnt), 32'(target));
    #1;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    bit empty;
    n = 0;
    do begin
      @(posedge CLKEXT);
      n++;
      empty = (exp_q.size() == 0);
      for (int i = 0; i < NR; i++) if (src_q[i].size() != 0) empty = 0;
    end while (!empty && n < budget);
    if (!empty) check_val("timeout_drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge CLKEXT);
    #1;
  endtask

  task automatic check_grant(input string tag, input int pos, input int expv);
    if (pos < grant_log.size()) check_val(tag, 32'(grant_log[pos]), 32'(expv));
    else check_val({tag, "_missing"}, 32'(grant_log.size()), 32'(pos + 1));
  endtask

  int gb, wb, d0, t0, w0;
  int exp_ord [$];

  initial begin
    RST_GLO = 1'b1;
    bus.EN_ARB = 1'b1;
    bus.FIFO_FULL = 1'b0;
    drive_reqs();

    // Reset with every requester valid.
    for (int i = 0; i < NR; i++) begin
      push_beat(i, 8'(8'h10 + i), 1'b1);
      exp_q.push_back(8'(8'h10 + i));
    end
    repeat (3) @(posedge CLKEXT);
    #2;
    check_val("rst_ready", 32'(bus.REQ_READY), 32'd0);
    check_val("rst_wr_en", 32'(bus.FIFO_WR_EN), 32'd0);
    check_val("rst_data", 32'(bus.FIFO_DATA), 32'd0);
    check_val("rst_grant", 32'(bus.GRANT_IDX), 32'd0);
    check_val("rst_busy", 32'(bus.ARB_BUSY), 32'd0);
    check_val("rst_done", 32'(bus.PKT_DONE), 32'd0);
    check_val("rst_trunc", 32'(bus.PKT_TRUNC), 32'd0);
    RST_GLO = 1'b0;
    @(posedge CLKEXT);
    #1;
    check_val("first_grant_busy", 32'(bus.ARB_BUSY), 32'd1);
    check_val("first_grant_idx", 32'(bus.GRANT_IDX), 32'd0);
    wait_drain(100);
    for (int k = 0; k < 4; k++) check_grant("t1_order", k, k);

    // Continuous single-beat packets from all requesters.
    gb = grant_log.size();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NR; i++) push_beat(i, 8'(8'h50 + 16 * r + i), 1'b1);
`ifdef FIFO_ARB_PRIO0_EN
    exp_ord = '{0, 0, 1, 2, 3, 1, 2, 3};
    foreach (exp_ord[k]) exp_q.push_back(8'(8'h50 + (k == 1 || k >= 5 ? 16 : 0) + exp_ord[k]));
`else
    exp_ord = '{0, 1, 2, 3, 0, 1, 2, 3};
    foreach (exp_ord[k]) exp_q.push_back(8'(8'h50 + (k >= 4 ? 16 : 0) + exp_ord[k]));
`endif
    wait_drain(200);
    for (int k = 0; k < 6; k++) check_grant("rr_order", gb + k, exp_ord[k]);

    // Two 2-beat packets, requested together.
    gb = grant_log.size(); wb = wr_cyc.size(); d0 = done_cnt;
    push_beat(0, 8'hA1, 1'b0); push_beat(0, 8'hA2, 1'b1);
    push_beat(2, 8'hC1, 1'b0); push_beat(2, 8'hC2, 1'b1);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    exp_q.push_back(8'hC1); exp_q.push_back(8'hC2);
    wait_drain(100);
    check_val("t2_done_cnt", 32'(done_cnt - d0), 32'd2);
    check_grant("t2_grant_a", gb, 0);
    check_grant("t2_grant_c", gb + 1, 2);
    if (wr_cyc.size() >= wb + 3) begin
      check_val("t2_beat_gap", 32'(wr_cyc[wb + 1] - wr_cyc[wb]), 32'd1);
      check_val("t2_idle_gap", 32'(wr_cyc[wb + 2] - wr_cyc[wb + 1]), 32'd2);
    end else check_val("t2_wr_count", 32'(wr_cyc.size() - wb), 32'd4);

    // Search resumes at 3 after requester 2's release.
    gb = grant_log.size();
    push_beat(1, 8'h31, 1'b1); push_beat(3, 8'h33, 1'b1);
    exp_q.push_back(8'h33); exp_q.push_back(8'h31);
    wait_drain(100);
    check_grant("ptr_grant_3", gb, 3);
    check_grant("ptr_grant_1", gb + 1, 1);

    // FIFO_FULL stall, then EN_ARB freeze, inside a 3-beat packet.
    w0 = wr_cnt;
    push_beat(2, 8'hB1, 1'b0); push_beat(2, 8'hB2, 1'b0); push_beat(2, 8'hB3, 1'b1);
    exp_q.push_back(8'hB1); exp_q.push_back(8'hB2); exp_q.push_back(8'hB3);
    wait_writes(w0 + 1, 50);
    bus.FIFO_FULL = 1'b1;
    repeat (3) begin
      @(negedge CLKEXT);
      check_val("full_wr_en", 32'(bus.FIFO_WR_EN), 32'd0);
      check_val("full_ready", 32'(bus.REQ_READY), 32'd0);
      check_val("full_busy", 32'(bus.ARB_BUSY), 32'd1);
    end
    @(posedge CLKEXT);
    #1 bus.FIFO_FULL = 1'b0;
    @(negedge CLKEXT);
    check_val("full_drop_wr", 32'(bus.FIFO_WR_EN), 32'd1);
    wait_writes(w0 + 2, 10);
    bus.EN_ARB = 1'b0;
    repeat (2) begin
      @(negedge CLKEXT);
      check_val("dis_ready", 32'(bus.REQ_READY), 32'd0);
      check_val("dis_busy", 32'(bus.ARB_BUSY), 32'd1);
      check_val("dis_owner", 32'(bus.GRANT_IDX), 32'd2);
    end
    @(posedge CLKEXT);
    #1 bus.EN_ARB = 1'b1;
    wait_drain(100);
    check_val("stall_beats", 32'(wr_cnt - w0), 32'd3);

    // 20-beat stream from requester 1, truncated at 16 beats.
    gb = grant_log.size(); w0 = wr_cnt; d0 = done_cnt; t0 = trunc_cnt;
    for (int b = 0; b < 20; b++) push_beat(1, 8'(b), b == 19);
    for (int b = 0; b < 16; b++) exp_q.push_back(8'(b));
    wait_writes(w0 + 1, 50);
    push_beat(0, 8'h70, 1'b1); push_beat(2, 8'h72, 1'b1); push_beat(3, 8'h73, 1'b1);
`ifdef FIFO_ARB_PRIO0_EN
    exp_ord = '{1, 0, 2, 3, 1};
`else
    exp_ord = '{1, 2, 3, 0, 1};
`endif
    for (int k = 1; k < 4; k++) exp_q.push_back(8'(8'h70 + exp_ord[k]));
    for (int b = 16; b < 20; b++) exp_q.push_back(8'(b));
    wait_drain(300);
    check_val("trunc_cnt", 32'(trunc_cnt - t0), 32'd1);
    check_val("trunc_done_cnt", 32'(done_cnt - d0), 32'd5);
    for (int k = 0; k < 5; k++) check_grant("trunc_order", gb + k, exp_ord[k]);

    // Reset in the middle of a 4-beat packet.
    w0 = wr_cnt;
    push_beat(2, 8'hE0, 1'b0); push_beat(2, 8'hE1, 1'b0);
    push_beat(2, 8'hE2, 1'b0); push_beat(2, 8'hE3, 1'b1);
    exp_q.push_back(8'hE0); exp_q.push_back(8'hE1);
    wait_writes(w0 + 2, 50);
    #1 RST_GLO = 1'b1;
    #1;
    check_val("mid_rst_ready", 32'(bus.REQ_READY), 32'd0);
    check_val("mid_rst_wr_en", 32'(bus.FIFO_WR_EN), 32'd0);
    check_val("mid_rst_busy", 32'(bus.ARB_BUSY), 32'd0);
    check_val("mid_rst_data", 32'(bus.FIFO_DATA), 32'd0);
    check_val("mid_rst_grant", 32'(bus.GRANT_IDX), 32'd0);
    for (int i = 0; i < NR; i++) src_q[i].delete();
    drive_reqs();
    repeat (2) @(posedge CLKEXT);
    #2 RST_GLO = 1'b0;
    gb = grant_log.size();
    push_beat(1, 8'hF1, 1'b1); push_beat(2, 8'hF2, 1'b1);
    exp_q.push_back(8'hF1); exp_q.push_back(8'hF2);
    wait_drain(100);
    check_grant("post_rst_grant_1", gb, 1);
    check_grant("post_rst_grant_2", gb + 1, 2);
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
